// File: rtl/pulse_frame_pkg.sv
// Shared types for the pulse-width coded frame receiver: FSM states,
// line level constants and the per-space classification result.
package pulse_frame_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SPACE = 2'd1,
    MARK  = 2'd2,
    ERR   = 2'd3
  } state_t;

  // Line levels: mark is the idle level, a space is a pulse.
  localparam logic LINE_MARK  = 1'b1;
  localparam logic LINE_SPACE = 1'b0;

  typedef enum logic [1:0] {
    BIT0 = 2'd0,
    BIT1 = 2'd1,
    BAD  = 2'd2
  } class_t;

endpackage

// File: rtl/pulse_classifier.sv
// Line front end: synchronises rxd, measures how long the synchronised level
// has been stable, and classifies each space as a 1, a 0 or a bad pulse.
module pulse_classifier
  import pulse_frame_pkg::*;
#(
  parameter int SHORT_MIN = 2,
  parameter int SHORT_MAX = 7,
  parameter int LONG_MIN  = 11,
  parameter int LONG_MAX  = 15,
  parameter int CNT_W     = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             rxd,
  output logic             rxs,
  output logic             space_end,
  output class_t           space_class,
  output logic             space_over,
  output logic [CNT_W-1:0] mark_len
);

  localparam logic [CNT_W-1:0] SHORT_MIN_C = CNT_W'(SHORT_MIN);
  localparam logic [CNT_W-1:0] SHORT_MAX_C = CNT_W'(SHORT_MAX);
  localparam logic [CNT_W-1:0] LONG_MIN_C  = CNT_W'(LONG_MIN);
  localparam logic [CNT_W-1:0] LONG_MAX_C  = CNT_W'(LONG_MAX);

  logic [1:0]       sync;
  logic             lvl;
  logic [CNT_W-1:0] len;

  // Two-flop synchroniser; resets to mark so a quiet line never looks like a pulse.
  // NOTE: sequential state uses <= so every flop samples pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) sync <= {2{LINE_MARK}};
    else       sync <= {sync[0], rxd};
  end

  assign rxs = sync[1];

  // Length of the current rxs level: restarts at 1 on a level change, saturates at all-ones.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      lvl <= LINE_MARK;
      len <= '0;
    end else begin
      lvl <= rxs;
      if (rxs != lvl)    len <= CNT_W'(1);
      else if (len != '1) len <= len + 1'b1;
    end
  end

  // Window compare on the length of the space that is ending.
  // NOTE: default assigned first so no path through the block infers a latch.
  always_comb begin
    space_class = BAD;
    if (len >= SHORT_MIN_C && len <= SHORT_MAX_C)    space_class = BIT1;
    else if (len >= LONG_MIN_C && len <= LONG_MAX_C) space_class = BIT0;
  end

  assign space_end  = (lvl == LINE_SPACE) && (rxs == LINE_MARK);
  assign space_over = (lvl == LINE_SPACE) && (len > LONG_MAX_C);
  assign mark_len   = (lvl == LINE_MARK) ? len : '0;

endmodule

// File: rtl/pulse_frame_receiver.sv
// Pulse-width coded frame receiver: assembles address+data words bit by bit,
// publishes the data field when the address matches, and counts framing errors.
module pulse_frame_receiver
  import pulse_frame_pkg::*;
#(
  parameter int ADDR_W      = 5,
  parameter int DATA_W      = 3,
  parameter int SHORT_MIN   = 2,
  parameter int SHORT_MAX   = 7,
  parameter int LONG_MIN    = 11,
  parameter int LONG_MAX    = 15,
  parameter int GAP_TIMEOUT = 30,
  parameter int CNT_W       = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              rxd,
  input  logic [ADDR_W-1:0] ref_addr,
  input  logic              msb_first,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic              frame_err,
  output logic [7:0]        err_count
);

  localparam int                WORD_W   = ADDR_W + DATA_W;
  localparam int                IDX_W    = $clog2(WORD_W);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(WORD_W - 1);
  localparam logic [CNT_W-1:0]  GAP_C    = CNT_W'(GAP_TIMEOUT);

  logic             rxs;
  logic             space_end;
  class_t           space_class;
  logic             space_over;
  logic [CNT_W-1:0] mark_len;

  state_t              state;
  logic [IDX_W-1:0]    bit_idx;
  logic [WORD_W-1:0]   word;
  logic                order_q;

  logic                cur_msb;
  logic [IDX_W-1:0]    pos;
  logic [WORD_W-1:0]   word_nxt;
  logic                addr_match;
  logic                go_err;

  pulse_classifier #(
    .SHORT_MIN (SHORT_MIN),
    .SHORT_MAX (SHORT_MAX),
    .LONG_MIN  (LONG_MIN),
    .LONG_MAX  (LONG_MAX),
    .CNT_W     (CNT_W)
  ) u_classifier (
    .clock       (clock),
    .reset       (reset),
    .rxd         (rxd),
    .rxs         (rxs),
    .space_end   (space_end),
    .space_class (space_class),
    .space_over  (space_over),
    .mark_len    (mark_len)
  );

  // Word with the bit being classified inserted, plus the error-entry decision.
  always_comb begin
    cur_msb     = (bit_idx == '0) ? msb_first : order_q;
    pos         = cur_msb ? (LAST_IDX - bit_idx) : bit_idx;
    word_nxt    = word;
    word_nxt[pos] = (space_class == BIT1);
    addr_match  = (word_nxt[WORD_W-1:DATA_W] == ref_addr);
    go_err      = 1'b0;
    case (state)
      SPACE:   go_err = space_end ? (space_class == BAD) : space_over;
      MARK:    go_err = (rxs == LINE_MARK) && (mark_len > GAP_C) && (bit_idx != '0);
      default: go_err = 1'b0;
    endcase
  end

  // Receiver FSM with word assembly, address compare and saturating error count.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      bit_idx    <= '0;
      word       <= '0;
      order_q    <= 1'b0;
      data_out   <= '0;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
      err_count  <= '0;
    end else begin
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
      if (go_err) begin
        state     <= ERR;
        frame_err <= 1'b1;
        bit_idx   <= '0;
        if (err_count != 8'hFF) err_count <= err_count + 8'd1;
      end else begin
        case (state)
          IDLE: if (rxs == LINE_SPACE) state <= SPACE;
          SPACE: begin
            if (space_end) begin
              state <= MARK;
              word  <= word_nxt;
              if (bit_idx == '0) order_q <= msb_first;
              if (bit_idx == LAST_IDX) begin
                bit_idx <= '0;
                if (addr_match) begin
                  data_out   <= word_nxt[DATA_W-1:0];
                  data_valid <= 1'b1;
                end
              end else begin
                bit_idx <= bit_idx + 1'b1;
              end
            end
          end
          MARK: begin
            if (rxs == LINE_SPACE)    state <= SPACE;
            else if (mark_len > GAP_C) state <= IDLE;
          end
          ERR: if (rxs == LINE_MARK && mark_len >= GAP_C) state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pulse_frame_receiver.sv
// Scoreboard bench for pulse_frame_receiver: stimulus pushes expected data
// words and expected error counts; a monitor pops them when the DUT pulses.
module tb_pulse_frame_receiver;

  logic       clock = 1'b0;
  logic       reset;
  logic       rxd;
  logic [4:0] ref_addr;
  logic       msb_first;
  logic [2:0] data_out;
  logic       data_valid;
  logic       frame_err;
  logic [7:0] err_count;

  int         n_checks = 0;
  int         n_errors = 0;
  logic [2:0] exp_q[$];
  logic [7:0] err_q[$];
  int         exp_errs = 0;
  time        last_rise = 0;
  logic [2:0] mon_data;
  logic [7:0] mon_cnt;

  pulse_frame_receiver dut (
    .clock      (clock),
    .reset      (reset),
    .rxd        (rxd),
    .ref_addr   (ref_addr),
    .msb_first  (msb_first),
    .data_out   (data_out),
    .data_valid (data_valid),
    .frame_err  (frame_err),
    .err_count  (err_count)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Drive a line level for n clocks; called at a negedge, returns at a negedge.
  task automatic level(input logic v, input int n);
    if (v && !rxd) last_rise = $time;
    rxd = v;
    repeat (n) @(negedge clock);
  endtask

  // Send the first nbits bits of w in the given order, 20-clock mark after each.
  task automatic send_bits(input logic [7:0] w, input logic msb, input int nbits,
                           input int s1, input int s0, input int toggle_at);
    msb_first = msb;
    for (int i = 0; i < nbits; i++) begin
      logic b;
      if (i == toggle_at) msb_first = ~msb_first;
      b = msb ? w[7-i] : w[i];
      level(1'b0, b ? s1 : s0);
      level(1'b1, 20);
    end
  endtask

  task automatic expect_err();
    exp_errs = (exp_errs < 255) ? exp_errs + 1 : 255;
    err_q.push_back(8'(exp_errs));
  endtask

  // Monitor: pop and compare on every output pulse.
  always @(negedge clock) begin
    if (!reset && (data_valid || frame_err)) begin
      check("valid_err_exclusive", {31'd0, data_valid & frame_err}, 32'd0);
      if (data_valid) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_valid: data_out=%0d, expected no output", data_out);
        end else begin
          mon_data = exp_q.pop_front();
          check("data_out", {29'd0, data_out}, {29'd0, mon_data});
          check("valid_latency_ns", 32'($time - last_rise), 32'd30);
        end
      end
      if (frame_err) begin
        if (err_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_frame_err: err_count=%0d, expected no error", err_count);
        end else begin
          mon_cnt = err_q.pop_front();
          check("err_count_at_err", {24'd0, err_count}, {24'd0, mon_cnt});
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  initial begin
    reset     = 1'b1;
    rxd       = 1'b1;
    msb_first = 1'b0;
    ref_addr  = 5'b01010;
    repeat (3) @(negedge clock);
    check("reset_data_out",   {29'd0, data_out},   32'd0);
    check("reset_data_valid", {31'd0, data_valid}, 32'd0);
    check("reset_frame_err",  {31'd0, frame_err},  32'd0);
    check("reset_err_count",  {24'd0, err_count},  32'd0);
    reset = 1'b0;
    level(1'b1, 10);

    // Valid words, LSB first, at the short/long window edges and centres.
    exp_q.push_back(3'd2); send_bits({5'b01010, 3'd2}, 1'b0, 8, 2, 11, -1);
    exp_q.push_back(3'd4); send_bits({5'b01010, 3'd4}, 1'b0, 8, 7, 15, -1);
    exp_q.push_back(3'd6); send_bits({5'b01010, 3'd6}, 1'b0, 8, 4, 13, -1);
    level(1'b1, 40);

    // Address mismatches: silently dropped.
    send_bits({5'b10101, 3'd1}, 1'b0, 8, 4, 13, -1);
    send_bits({5'b10101, 3'd3}, 1'b0, 8, 4, 13, -1);
    level(1'b1, 10);
    check("hold_after_mismatch", {29'd0, data_out}, 32'd6);
    check("no_err_after_mismatch", {24'd0, err_count}, 32'd0);

    // 9-clock space (between windows) mid-word, then resync and a good word.
    send_bits({5'b01010, 3'd5}, 1'b0, 3, 4, 13, -1);
    expect_err();
    level(1'b0, 9);
    level(1'b1, 40);
    check("err_count_gap_space", {24'd0, err_count}, 32'd1);
    exp_q.push_back(3'd5); send_bits({5'b01010, 3'd5}, 1'b0, 8, 4, 13, -1);
    level(1'b1, 10);
    check("data_after_resync", {29'd0, data_out}, 32'd5);

    // 40-clock mark after 4 bits, then a 20-clock space.
    send_bits({5'b01010, 3'd1}, 1'b0, 4, 4, 13, -1);
    expect_err();
    level(1'b1, 20);
    expect_err();
    level(1'b0, 20);
    level(1'b1, 40);
    check("err_count_timeouts", {24'd0, err_count}, 32'd3);
    check("hold_after_truncated", {29'd0, data_out}, 32'd5);

    // MSB-first, then msb_first toggled mid-word (must not affect that word).
    ref_addr = 5'b10011;
    exp_q.push_back(3'd6); send_bits(8'b10011_110, 1'b1, 8, 4, 13, -1);
    exp_q.push_back(3'd3); send_bits(8'b10011_011, 1'b1, 8, 4, 13, 3);
    level(1'b1, 10);
    check("msb_toggle_word", {29'd0, data_out}, 32'd3);

    // Reset during bit 5 of a word.
    send_bits({5'b10011, 3'd7}, 1'b0, 4, 4, 13, -1);
    rxd = 1'b0;
    repeat (5) @(negedge clock);
    reset = 1'b1;
    #1;
    check("midreset_data_out",   {29'd0, data_out},   32'd0);
    check("midreset_data_valid", {31'd0, data_valid}, 32'd0);
    check("midreset_frame_err",  {31'd0, frame_err},  32'd0);
    check("midreset_err_count",  {24'd0, err_count},  32'd0);
    rxd = 1'b1;
    repeat (3) @(negedge clock);
    reset    = 1'b0;
    exp_errs = 0;
    level(1'b1, 10);
    exp_q.push_back(3'd7); send_bits({5'b10011, 3'd7}, 1'b0, 8, 4, 13, -1);
    level(1'b1, 10);
    check("word_after_reset", {29'd0, data_out}, 32'd7);
    check("err_count_after_reset", {24'd0, err_count}, 32'd0);

    // 300 too-short spaces: counter saturates at 255.
    for (int i = 0; i < 300; i++) begin
      expect_err();
      level(1'b0, 1);
      level(1'b1, 32);
    end
    level(1'b1, 10);
    check("err_count_saturated", {24'd0, err_count}, 32'd255);
    check("data_queue_drained", 32'(exp_q.size()), 32'd0);
    check("err_queue_drained", 32'(err_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
